// File: rtl/scc_run_ctrl.sv
// Run-control sequencer for the scc_f25_top core: reset/clock-enable gating,
// halt/error/watchdog supervision, then a valid/ready dump of a data-memory window.
module scc_run_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 100000,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic              core_rst,
  output logic              core_clk_en,
  input  logic              halt_f,
  input  logic [1:0]        err_bits,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_addr,
  output logic [31:0]       dump_data,
  output logic [31:0]       cycle_count,
  output logic [2:0]        status,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_RUN, S_RD, S_RDW, S_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DUMP_WORDS - 1);
  localparam logic [31:0]     TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [31:0]     RST_C     = 32'(RST_CYCLES);
  localparam logic [31:0]     BASE_C    = 32'(DUMP_BASE);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUNNING = 3'd1;
  localparam logic [2:0] ST_HALTED  = 3'd2;
  localparam logic [2:0] ST_ERROR   = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  state_t          state_q, state_d;
  logic            step_mode_q, step_mode_d;
  logic            step_pend_q, step_pend_d;
  logic [31:0]     rst_cnt_q, rst_cnt_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic [2:0]      status_q, status_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic            dump_valid_q, dump_valid_d;
  logic [31:0]     dump_addr_q, dump_addr_d;
  logic [31:0]     dump_data_q, dump_data_d;

  logic [31:0]     word_addr;
  logic            begin_run;
  logic            run_exit;

  assign word_addr = BASE_C + 32'(idx_q);

  always_comb begin
    state_d       = state_q;
    step_mode_d   = step_mode_q;
    step_pend_d   = step_pend_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    status_d      = status_q;
    idx_d         = idx_q;
    dump_valid_d  = dump_valid_q;
    dump_addr_d   = dump_addr_q;
    dump_data_d   = dump_data_q;
    core_rst      = 1'b0;
    core_clk_en   = 1'b0;
    mem_rd_en     = 1'b0;
    mem_addr      = '0;
    done          = 1'b0;
    begin_run     = 1'b0;
    run_exit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        core_rst  = 1'b1;
        begin_run = start;
      end
      S_CRST: begin
        core_rst = 1'b1;
        if (rst_cnt_q <= 32'd1) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 32'd1;
        end
      end
      S_RUN: begin
        // Exit priority: error, then halt, then watchdog; the enable is
        // suppressed in the exit cycle so the core freezes immediately.
        if (err_bits != 2'b00) begin
          status_d = ST_ERROR;
          run_exit = 1'b1;
        end else if (halt_f) begin
          status_d = ST_HALTED;
          run_exit = 1'b1;
        end else if (cycle_count_q >= TIMEOUT_C) begin
          status_d = ST_TIMEOUT;
          run_exit = 1'b1;
        end else begin
          core_clk_en = step_mode_q ? step_pend_q : 1'b1;
        end
        // A step seen while an enable is already pending is dropped.
        step_pend_d = step_mode_q && step && !step_pend_q;
        if (run_exit) begin
          state_d     = S_RD;
          idx_d       = '0;
          step_pend_d = 1'b0;
        end
      end
      S_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = word_addr[ADDR_W-1:0];
        state_d   = S_RDW;
      end
      S_RDW: begin
        dump_data_d  = mem_rd_data;
        dump_addr_d  = word_addr << 2;
        dump_valid_d = 1'b1;
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        begin_run = start;
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_run) begin
      step_mode_d   = step_mode;
      step_pend_d   = 1'b0;
      cycle_count_d = '0;
      rst_cnt_d     = RST_C;
      status_d      = ST_RUNNING;
      state_d       = S_CRST;
    end

    if (core_clk_en && (cycle_count_q != 32'hFFFF_FFFF)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      step_mode_q   <= 1'b0;
      step_pend_q   <= 1'b0;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      status_q      <= ST_IDLE;
      idx_q         <= '0;
      dump_valid_q  <= 1'b0;
      dump_addr_q   <= '0;
      dump_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      step_mode_q   <= step_mode_d;
      step_pend_q   <= step_pend_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      status_q      <= status_d;
      idx_q         <= idx_d;
      dump_valid_q  <= dump_valid_d;
      dump_addr_q   <= dump_addr_d;
      dump_data_q   <= dump_data_d;
    end
  end

  assign dump_valid  = dump_valid_q;
  assign dump_addr   = dump_addr_q;
  assign dump_data   = dump_data_q;
  assign cycle_count = cycle_count_q;
  assign status      = status_q;

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Bench for scc_run_ctrl: two instances (256-word dump, and TIMEOUT=20 with a
// 4-word dump) driven one at a time by a table of runs plus directed sequences.
module tb_scc_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, step_mode, step, halt_f, dump_ready;
  logic [1:0] err_bits;

  logic        core_rst_a, en_a, mem_rd_en_a, dv_a, done_a;
  logic [7:0]  mem_addr_a;
  logic [31:0] rd_data_a, da_a, dd_a, cc_a;
  logic [2:0]  st_a;
  logic        core_rst_b, en_b, mem_rd_en_b, dv_b, done_b;
  logic [7:0]  mem_addr_b;
  logic [31:0] rd_data_b, da_b, dd_b, cc_b;
  logic [2:0]  st_b;

  scc_run_ctrl #(.ADDR_W(8), .RST_CYCLES(3), .TIMEOUT(100000), .DUMP_BASE(0), .DUMP_WORDS(256)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .step_mode(step_mode), .step(step),
    .core_rst(core_rst_a), .core_clk_en(en_a), .halt_f(halt_f), .err_bits(err_bits),
    .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a), .mem_rd_data(rd_data_a),
    .dump_valid(dv_a), .dump_ready(dump_ready), .dump_addr(da_a), .dump_data(dd_a),
    .cycle_count(cc_a), .status(st_a), .done(done_a)
  );

  scc_run_ctrl #(.ADDR_W(8), .RST_CYCLES(3), .TIMEOUT(20), .DUMP_BASE(0), .DUMP_WORDS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .step_mode(step_mode), .step(step),
    .core_rst(core_rst_b), .core_clk_en(en_b), .halt_f(halt_f), .err_bits(err_bits),
    .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rd_data(rd_data_b),
    .dump_valid(dv_b), .dump_ready(dump_ready), .dump_addr(da_b), .dump_data(dd_b),
    .cycle_count(cc_b), .status(st_b), .done(done_b)
  );

  function automatic logic [31:0] mem_fn(input logic [7:0] a);
    return {(a[7] ? 8'hC3 : 8'h00), 16'h0000, a ^ 8'h56};
  endfunction

  // Data memory model with a one-cycle registered read.
  always @(posedge clk) begin
    if (mem_rd_en_a) rd_data_a <= mem_fn(mem_addr_a);
    if (mem_rd_en_b) rd_data_b <= mem_fn(mem_addr_b);
  end

  logic act;
  logic        core_rst_m, en_m, dv_m, done_m;
  logic [31:0] da_m, dd_m, cc_m;
  logic [2:0]  st_m;
  assign core_rst_m = act ? core_rst_b : core_rst_a;
  assign en_m       = act ? en_b : en_a;
  assign dv_m       = act ? dv_b : dv_a;
  assign done_m     = act ? done_b : done_a;
  assign da_m       = act ? da_b : da_a;
  assign dd_m       = act ? dd_b : dd_a;
  assign cc_m       = act ? cc_b : cc_a;
  assign st_m       = act ? st_b : st_a;

  int checks = 0;
  int failures = 0;
  int beats;
  logic hold, post_hs, en_seen;
  logic [31:0] held_a, held_d;
  int en_cnt, halt_at, err_at;
  logic [1:0] err_val;

  typedef struct {
    logic       inst;
    int         halt_at;
    int         err_at;
    logic [1:0] err_val;
    logic [2:0] exp_status;
    int         exp_cc;
    int         exp_beats;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic upd_core();
    halt_f   = (halt_at != 0) && (en_cnt >= halt_at);
    err_bits = ((err_at != 0) && (en_cnt >= err_at)) ? err_val : 2'b00;
  endtask

  // Dump-stream monitor, evaluated mid-cycle.
  task automatic monitor();
    if (post_hs) begin
      chk("valid_low_after_hs", {31'd0, dv_m}, 32'd0);
      post_hs = 1'b0;
    end
    if (hold) begin
      chk("stall_valid", {31'd0, dv_m}, 32'd1);
      chk("stall_addr", da_m, held_a);
      chk("stall_data", dd_m, held_d);
      hold = 1'b0;
    end
    if (dv_m) begin
      if (dump_ready) begin
        chk("beat_addr", da_m, 32'(beats * 4));
        chk("beat_data", dd_m, mem_fn(8'(beats)));
        if (beats == 100) begin
          chk("beat100_addr", da_m, 32'h190);
          chk("beat100_data", dd_m, 32'h32);
        end
        beats++;
        post_hs = 1'b1;
      end else begin
        hold   = 1'b1;
        held_a = da_m;
        held_d = dd_m;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    en_seen = en_m;
    @(posedge clk);
    #1;
    if (en_seen) en_cnt++;
    upd_core();
  endtask

  task automatic do_start(input logic inst);
    act     = inst;
    beats   = 0;
    hold    = 1'b0;
    post_hs = 1'b0;
    en_cnt  = 0;
    upd_core();
    if (inst) start_b = 1'b1; else start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done_m && n < limit) begin
      cyc();
      n++;
    end
    chk("done_reached", {31'd0, done_m}, 32'd1);
  endtask

  task automatic run_vec(input int i);
    int n;
    int crst;
    step_mode  = 1'b0;
    dump_ready = 1'b1;
    halt_at    = vecs[i].halt_at;
    err_at     = vecs[i].err_at;
    err_val    = vecs[i].err_val;
    do_start(vecs[i].inst);
    crst = 0;
    n = 0;
    while (core_rst_m === 1'b1 && n < 20) begin
      crst++;
      cyc();
      n++;
    end
    chk("crst_cycles", 32'(crst), 32'd3);
    chk("run_status", {29'd0, st_m}, 32'd1);
    wait_done(2000);
    chk("final_status", {29'd0, st_m}, {29'd0, vecs[i].exp_status});
    chk("final_cycles", cc_m, 32'(vecs[i].exp_cc));
    chk("en_pulses", 32'(en_cnt), 32'(vecs[i].exp_cc));
    chk("beat_count", 32'(beats), 32'(vecs[i].exp_beats));
    chk("done_en_low", {31'd0, en_m}, 32'd0);
    $display("run %0d inst=%0d status=%0d cycles=%0d beats=%0d", i, vecs[i].inst, st_m, cc_m, beats);
  endtask

  initial begin
    int n;
    int stall_left;
    logic tog;

    vecs[0] = '{1'b0, 50, 0,  2'b00, 3'd2, 50, 256};
    vecs[1] = '{1'b0, 30, 30, 2'b01, 3'd3, 30, 256};
    vecs[2] = '{1'b0, 0,  7,  2'b10, 3'd3, 7,  256};
    vecs[3] = '{1'b1, 0,  0,  2'b00, 3'd4, 20, 4};
    vecs[4] = '{1'b1, 1,  0,  2'b00, 3'd2, 1,  4};
    vecs[5] = '{1'b1, 19, 0,  2'b00, 3'd2, 19, 4};
    vecs[6] = '{1'b1, 20, 0,  2'b00, 3'd2, 20, 4};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; step_mode = 1'b0; step = 1'b0;
    dump_ready = 1'b1; act = 1'b0; halt_at = 0; err_at = 0; err_val = 2'b00;
    en_cnt = 0; beats = 0; hold = 1'b0; post_hs = 1'b0; en_seen = 1'b0;
    held_a = '0; held_d = '0;
    upd_core();
    repeat (3) cyc();
    rst = 1'b0;

    chk("rst_core_rst", {31'd0, core_rst_a}, 32'd1);
    chk("rst_clk_en", {31'd0, en_a}, 32'd0);
    chk("rst_mem_rd_en", {31'd0, mem_rd_en_a}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr_a}, 32'd0);
    chk("rst_dump_valid", {31'd0, dv_a}, 32'd0);
    chk("rst_dump_addr", da_a, 32'd0);
    chk("rst_dump_data", dd_a, 32'd0);
    chk("rst_cycle_count", cc_a, 32'd0);
    chk("rst_status", {29'd0, st_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Single-step: five steps 4 cycles apart, the third held two cycles.
    act = 1'b0; halt_at = 5; err_at = 0; dump_ready = 1'b1; step_mode = 1'b1;
    do_start(1'b0);
    n = 0;
    while (core_rst_m === 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    chk("start_ignored_in_run", {31'd0, core_rst_m}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step = 1'b1;
      cyc();
      chk("step_en_c0", {31'd0, en_seen}, 32'd0);
      step = (k == 2);
      cyc();
      chk("step_en_c1", {31'd0, en_seen}, 32'd1);
      step = 1'b0;
      cyc();
      chk("step_en_c2", {31'd0, en_seen}, 32'd0);
      cyc();
      chk("step_en_c3", {31'd0, en_seen}, 32'd0);
    end
    step_mode = 1'b0;
    wait_done(2000);
    chk("step_status", {29'd0, st_m}, 32'd2);
    chk("step_cycles", cc_m, 32'd5);
    chk("step_pulses", 32'(en_cnt), 32'd5);
    $display("step run status=%0d cycles=%0d beats=%0d", st_m, cc_m, beats);

    // Backpressure on the 4-word instance: alternating ready, 3-cycle stall on beat 2.
    halt_at = 2; err_at = 0; dump_ready = 1'b1;
    do_start(1'b1);
    stall_left = 3;
    tog = 1'b1;
    n = 0;
    while (!done_m && n < 300) begin
      if (beats == 2 && dv_m && stall_left > 0) begin
        dump_ready = 1'b0;
        stall_left--;
      end else begin
        dump_ready = tog;
        tog = ~tog;
      end
      cyc();
      n++;
    end
    dump_ready = 1'b1;
    chk("bp_done", {31'd0, done_m}, 32'd1);
    chk("bp_stall_applied", 32'(stall_left), 32'd0);
    chk("bp_beats", 32'(beats), 32'd4);
    chk("bp_status", {29'd0, st_m}, 32'd2);
    chk("bp_cycles", cc_m, 32'd2);
    $display("backpressure run status=%0d cycles=%0d beats=%0d", st_m, cc_m, beats);

    // Reset while a beat is waiting in OUT, then a fresh full run.
    halt_at = 10; err_at = 0; dump_ready = 1'b1;
    do_start(1'b0);
    n = 0;
    while (beats < 5 && n < 500) begin
      cyc();
      n++;
    end
    dump_ready = 1'b0;
    n = 0;
    while (!dv_m && n < 10) begin
      cyc();
      n++;
    end
    chk("mid_dump_valid", {31'd0, dv_m}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    hold = 1'b0;
    post_hs = 1'b0;
    chk("abort_dump_valid", {31'd0, dv_a}, 32'd0);
    chk("abort_dump_addr", da_a, 32'd0);
    chk("abort_dump_data", dd_a, 32'd0);
    chk("abort_status", {29'd0, st_a}, 32'd0);
    chk("abort_cycle_count", cc_a, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    chk("abort_core_rst", {31'd0, core_rst_a}, 32'd1);
    chk("abort_clk_en", {31'd0, en_a}, 32'd0);
    chk("abort_mem_rd_en", {31'd0, mem_rd_en_a}, 32'd0);
    $display("reset mid-dump applied");
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scc_run_ctrl.md
Name: scc_run_ctrl

Overview:
- Run-control sequencer for the scc_f25_top core.
- Brings the core out of reset and gates its clk_en, with optional single-step.
- Watches halt_f, err_bits and a cycle watchdog.
- After the run ends, sweeps a window of data memory through a read port and streams address/value pairs over a valid/ready interface. This replaces the file-dump path used for self-checking.

Parameters:
- ADDR_W, 8: data memory word-address width.
- RST_CYCLES, 3: cycles core_rst is held after start (≥1).
- TIMEOUT, 100000: max RUN cycles before watchdog fault (≥1).
- DUMP_BASE, 0: first word address dumped.
- DUMP_WORDS, 256: words dumped (1..2^ADDR_W; the window must not exceed the memory).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; honoured only in IDLE or DONE.
- step_mode  in  1  1 = single-step; sampled at the start pulse.
- step  in  1  1-cycle pulse; advances core one cycle in step mode.
- core_rst  out  1  reset to core.
- core_clk_en  out  1  clk_en to core.
- halt_f  in  1  core halted.
- err_bits  in  2  core error code; nonzero = fault.
- mem_rd_en  out  1  data memory read strobe.
- mem_addr  out  ADDR_W  data memory word address.
- mem_rd_data  in  32  read data, valid the cycle after mem_rd_en.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts beat.
- dump_addr  out  32  byte address of beat = word address × 4.
- dump_data  out  32  word value.
- cycle_count  out  32  core-enabled cycles in the current run.
- status  out  3  0 idle, 1 running, 2 halted ok, 3 core error, 4 timeout.
- done  out  1  high in DONE.

Behaviour:
- Reset values: core_rst=1, core_clk_en=0, mem_rd_en=0, mem_addr=0, dump_valid=0, dump_addr=0, dump_data=0, cycle_count=0, status=0, done=0, state=IDLE. Reset mid-operation aborts immediately; no partial beat survives.
- IDLE: core_rst=1, core_clk_en=0. On start: latch step_mode, clear cycle_count, load rst counter = RST_CYCLES, status=1, go to CRST.
- CRST: core_rst=1 for exactly RST_CYCLES cycles, then RUN. core_rst is low from the first RUN cycle.
- RUN, free mode: core_clk_en=1 every cycle.
- RUN, step mode: core_clk_en=1 only in the cycle after a step pulse. Steps arriving while that enable is pending are dropped.
- cycle_count increments on every cycle with core_clk_en=1, and saturates at 0xFFFFFFFF.
- Exit checks, in priority order, evaluated every RUN cycle:
  1. err_bits≠0: status=3, go to RD.
  2. halt_f=1: status=2, go to RD.
  3. cycle_count reaches TIMEOUT: status=4, go to RD.
  - core_clk_en drops to 0 on the transition cycle.
  - If err and halt coincide, err wins.
- RD, RDW and OUT all hold core_clk_en=0 and core_rst=0, so core state stays frozen for inspection.
- RD: mem_rd_en=1, mem_addr=DUMP_BASE+idx; go to RDW.
  - idx starts at 0 and is ADDR_W+1 bits wide, so the last-beat compare does not wrap.
- RDW: mem_rd_en=0; capture mem_rd_data into dump_data and (DUMP_BASE+idx)<<2 into dump_addr; assert dump_valid; go to OUT.
- OUT: hold dump_valid, dump_addr and dump_data stable until dump_ready.
  - On the handshake cycle: if idx=DUMP_WORDS-1 go to DONE, else idx++ and go to RD.
  - dump_valid deasserts the cycle after the handshake. Best case is 3 cycles per beat.
- DONE: done=1; status, cycle_count and core_clk_en=0 hold. start re-enters CRST with done=0; there is no pass through IDLE.
- start outside IDLE/DONE is ignored. step is ignored outside step-mode RUN.
- dump_ready held high is legal. Never-asserted dump_ready stalls OUT indefinitely, with no timeout.

Test Plan:
- Free run, core halts after 50 enabled cycles → core_rst high for 3 cycles after start; status=2; cycle_count=50; with DUMP_WORDS=256 and dump_ready=1, 256 beats; beat 100 has dump_addr=0x190 and dump_data=0x32; done=1.
- err_bits=2'b01 and halt_f=1 in the same RUN cycle → status=3; core_clk_en low the next cycle; dump still completes.
- TIMEOUT=20, halt_f never asserts → status=4, cycle_count=20, dump runs.
- step_mode=1, five step pulses spaced 4 cycles apart, halt_f set after the fifth → exactly 5 single-cycle core_clk_en pulses; cycle_count=5.
- DUMP_WORDS=4, dump_ready toggling 1010… with a 3-cycle low stall on beat 2 → dump_addr/dump_data stable while stalled; exactly 4 beats; addresses 0x0, 0x4, 0x8, 0xC.
- rst asserted in OUT mid-dump → next cycle all outputs at reset values, dump_valid=0; a following start produces a full fresh run.
